// File: rtl/sc_stream_to_binary.sv
// Stochastic bitstream to binary converter: counts 1s over 2^WIDTH valid samples.
// Optional macro SC_STREAM_TO_BINARY_BIPOLAR_EN selects a bipolar (2*ones - N) result.
//
// state | meaning
// IDLE  | waiting for start; counters cleared
// ACCUM | counting valid samples of the window
// DONE  | result held until consumer handshake
module sc_stream_to_binary #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             busy,
   output logic [WIDTH+1:0] result,
   output logic             result_valid,
   input  logic             result_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   ones_cnt_q, ones_cnt_d;
   logic [WIDTH-1:0] sample_cnt_q, sample_cnt_d;
   logic [WIDTH+1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             busy_q, busy_d;

   logic             last_sample;
   logic             handshake;
   logic [WIDTH:0]   final_ones;
   logic [WIDTH+1:0] result_calc;

   assign last_sample = bit_valid & (&sample_cnt_q);
   assign handshake   = result_valid_q & result_ready;
   assign final_ones  = ones_cnt_q + (WIDTH+1)'(bit_in);

`ifdef SC_STREAM_TO_BINARY_BIPOLAR_EN
   // 2*ones - N; the subtraction wraps into two's complement within WIDTH+2 bits
   assign result_calc = {final_ones, 1'b0} - {2'b01, {WIDTH{1'b0}}};
`else
   assign result_calc = {1'b0, final_ones};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         ones_cnt_q     <= '0;
         sample_cnt_q   <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ones_cnt_q     <= ones_cnt_d;
         sample_cnt_q   <= sample_cnt_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         busy_q         <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (last_sample) state_d = S_DONE;
            S_DONE:  if (handshake) state_d = start ? S_ACCUM : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ones_cnt_d     = ones_cnt_q;
      sample_cnt_d   = sample_cnt_q;
      result_d       = result_q;
      busy_d         = (state_d == S_ACCUM);
      result_valid_d = (state_d == S_DONE);
      if (clear) begin
         ones_cnt_d   = '0;
         sample_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ones_cnt_d   = '0;
                  sample_cnt_d = '0;
               end
            end
            S_ACCUM: begin
               if (last_sample) begin
                  result_d     = result_calc;
                  ones_cnt_d   = '0;
                  sample_cnt_d = '0;
               end else if (bit_valid) begin
                  ones_cnt_d   = final_ones;
                  sample_cnt_d = sample_cnt_q + WIDTH'(1);
               end
            end
            S_DONE: begin
               if (handshake && start) begin
                  ones_cnt_d   = '0;
                  sample_cnt_d = '0;
               end
            end
            default: begin
               ones_cnt_d   = '0;
               sample_cnt_d = '0;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Directed bench for sc_stream_to_binary with WIDTH=4 (16-sample windows).
module tb_sc_stream_to_binary;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         clear = 1'b0;
   logic         bit_in = 1'b0;
   logic         bit_valid = 1'b0;
   logic         busy;
   logic [W+1:0] result;
   logic         result_valid;
   logic         result_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   sc_stream_to_binary #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .clear        (clear),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pattern;
      logic [31:0] stall;
      int          ones;
      int          cycles;
      string       name;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [W+1:0] exp_res(input int ones);
`ifdef SC_STREAM_TO_BINARY_BIPOLAR_EN
      return (W+2)'(2 * ones - 16);
`else
      return (W+2)'(ones);
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("rv_after_start", result_valid, 0);
   endtask

   // Feed 16 valid samples, inserting stall cycles where stall[cycle] is set.
   // Optional start pulses during ACCUM must have no effect.
   task automatic feed(input logic [15:0] pat, input logic [31:0] stall, input int ones,
                       input int exp_cyc, input bit poke_start, input string nm);
      int taken = 0;
      int cyc = 0;
      while (taken < 16 && cyc < 32) begin
         if (stall[cyc]) begin
            bit_valid = 1'b0;
            bit_in    = 1'b1;
         end else begin
            bit_valid = 1'b1;
            bit_in    = pat[taken];
            taken++;
         end
         start = poke_start & cyc[0];
         tick();
         cyc++;
         if (taken < 16) chk({nm, "_rv_early"}, result_valid, 0);
      end
      start = 1'b0;
      bit_valid = 1'b0;
      chk({nm, "_cycles"}, cyc, exp_cyc);
      chk({nm, "_rv"}, result_valid, 1);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_result"}, result, exp_res(ones));
   endtask

   task automatic accept();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("rv_after_accept", result_valid, 0);
      chk("busy_after_accept", busy, 0);
   endtask

   initial begin
      vecs[0] = '{16'hAAAA, 32'h0,          8, 16, "alt10"};
      vecs[1] = '{16'hFFFF, 32'h0000_0208, 16, 18, "ones_stall"};
      vecs[2] = '{16'h0000, 32'h0,          0, 16, "zeros"};
      vecs[3] = '{16'h000F, 32'h0000_0001,  4, 17, "four"};
      vecs[4] = '{16'h0FFF, 32'h0,         12, 16, "twelve"};
      vecs[5] = '{16'h8001, 32'h0000_C000,  2, 18, "two_ends"};

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_result", result, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         do_start();
         feed(vecs[i].pattern, vecs[i].stall, vecs[i].ones, vecs[i].cycles, 1'b0, vecs[i].name);
         accept();
      end

      // Held result under backpressure, with ignored start/samples.
      do_start();
      feed(16'h0000, 32'h0, 0, 16, 1'b0, "hold");
      for (int k = 0; k < 5; k++) begin
         start = 1'b1;
         bit_valid = 1'b1;
         bit_in = 1'b1;
         tick();
         chk("hold_rv", result_valid, 1);
         chk("hold_result", result, exp_res(0));
      end
      start = 1'b0;
      bit_valid = 1'b0;
      accept();

      // Handshake and start together: straight back into ACCUM.
      do_start();
      feed(16'h5555, 32'h0, 8, 16, 1'b0, "b2b_first");
      result_ready = 1'b1;
      start = 1'b1;
      tick();
      result_ready = 1'b0;
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_rv", result_valid, 0);
      feed(16'hFFFF, 32'h0, 16, 16, 1'b1, "b2b_second");
      accept();

      // Clear after 7 samples; result register keeps the last value.
      do_start();
      bit_valid = 1'b1;
      bit_in = 1'b1;
      for (int k = 0; k < 7; k++) tick();
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      bit_valid = 1'b0;
      chk("clr_busy", busy, 0);
      chk("clr_rv", result_valid, 0);
      chk("clr_result_kept", result, exp_res(16));
      do_start();
      feed(16'h0F00, 32'h0, 4, 16, 1'b0, "after_clear");
      accept();

      // Asynchronous reset mid-window.
      do_start();
      bit_valid = 1'b1;
      bit_in = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_rv", result_valid, 0);
      chk("arst_result", result, 0);
      bit_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_idle_busy", busy, 0);
      do_start();
      feed(16'hFFF0, 32'h0, 12, 16, 1'b0, "after_rst");
      accept();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
